// File: rtl/shifter_operand_ctrl_pkg.sv
// shifter_operand_ctrl_pkg: shared shift types, FSM states and Rs latency bounds
// Contents: shift_t (LSL/LSR/ASR/ROR), state_t (IDLE/RS_WAIT/EXEC/DONE), RS_LAT_MIN/RS_LAT_MAX
package shifter_operand_ctrl_pkg;
    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RS_WAIT, ST_EXEC, ST_DONE} state_t;
    localparam int RS_LAT_MIN = 1;
    localparam int RS_LAT_MAX = 3;
endpackage

// File: rtl/shifter_operand_ctrl_if.sv
// shifter_operand_if: request, Rs-read and result handshakes of the shifter operand sequencer
// slave  (the sequencer): in_valid/imm_form/instr/rm_val/c_in/rs_val/flush/out_ready in; in_ready/rs_req/out_valid/operand/carry_out out
// master (the requester): the mirror image
interface shifter_operand_if;
    logic        in_valid;
    logic        in_ready;
    logic        imm_form;
    logic [11:0] instr;
    logic [31:0] rm_val;
    logic        c_in;
    logic        rs_req;
    logic [7:0]  rs_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand;
    logic        carry_out;
    modport slave (input in_valid, imm_form, instr, rm_val, c_in, rs_val, flush, out_ready,
                   output in_ready, rs_req, out_valid, operand, carry_out);
    modport master (output in_valid, imm_form, instr, rm_val, c_in, rs_val, flush, out_ready,
                    input in_ready, rs_req, out_valid, operand, carry_out);
endinterface

// File: rtl/shifter_operand_ctrl_shifter.sv
// shifter_operand_ctrl_shifter: combinational 32-bit barrel shifter for amounts 1..31
// Ports: i_en gate, i_data value, i_amt amount (1..31), i_type shift type; o_result/o_carry (0 when disabled)
module shifter_operand_ctrl_shifter
    import shifter_operand_ctrl_pkg::*;
(
    input  logic        i_en,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    input  shift_t      i_type,
    output logic [31:0] o_result,
    output logic        o_carry
);
    // One guard bit on each side captures the last bit shifted out
    logic [32:0] w_left;
    logic [32:0] w_right;
    logic [31:0] w_asr;
    logic [31:0] w_rot;
    assign w_left  = {1'b0, i_data} << i_amt;
    assign w_right = {i_data, 1'b0} >> i_amt;
    assign w_asr   = $signed(i_data) >>> i_amt;
    assign w_rot   = (i_data >> i_amt) | (i_data << (~i_amt + 5'd1));
    always_comb begin
        o_result = !i_en ? '0 : i_type == SH_LSL ? w_left[31:0] : i_type == SH_LSR ? w_right[32:1] :
                   i_type == SH_ASR ? w_asr : w_rot;
        o_carry  = i_en & (i_type == SH_LSL ? w_left[32] : w_right[0]);
    end
endmodule

// File: rtl/shifter_operand_ctrl.sv
// shifter_operand_ctrl: ARM addressing-mode-1 shifter operand sequencer with Rs fetch and corner cases
// Ports: clk, reset_n (async active-low), bus (shifter_operand_if.slave); RS_LAT = Rs read latency 1..3
module shifter_operand_ctrl
    import shifter_operand_ctrl_pkg::*;
#(
    parameter int RS_LAT = 1
)(
    input  logic clk,
    input  logic reset_n,
    shifter_operand_if.slave bus
);
    localparam int LAT = RS_LAT < RS_LAT_MIN ? RS_LAT_MIN : RS_LAT > RS_LAT_MAX ? RS_LAT_MAX : RS_LAT;
    state_t      r_state, w_next;
    logic        r_imm, r_c, r_carry;
    logic [11:0] r_instr;
    logic [31:0] r_rm, r_operand;
    logic [7:0]  r_rs;
    logic [1:0]  r_cnt;
    logic        w_accept, w_last, w_reg_sh, w_use_sh, w_sh_carry, w_carry;
    logic [4:0]  w_rot;
    logic [31:0] w_imm_rot, w_sh_res, w_operand;
    shift_t      w_type;
    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_last    = r_cnt == 2'(LAT - 1);
    assign w_type    = shift_t'(r_instr[6:5]);
    assign w_reg_sh  = r_instr[4];
    assign w_rot     = {r_instr[11:8], 1'b0};
    assign w_imm_rot = ({24'd0, r_instr[7:0]} >> w_rot) | ({24'd0, r_instr[7:0]} << (~w_rot + 5'd1));
    // Only genuine 1..31 shifts reach the barrel shifter; everything else is resolved below
    assign w_use_sh  = !r_imm & (w_reg_sh ? (r_rs != 8'd0 & (w_type == SH_ROR ? r_rs[4:0] != 5'd0 : r_rs < 8'd32))
                                          : r_instr[11:7] != 5'd0);
    shifter_operand_ctrl_shifter u_shifter_32 (
        .i_en     (w_use_sh & (r_state == ST_EXEC)),
        .i_data   (r_rm),
        .i_amt    (w_reg_sh ? r_rs[4:0] : r_instr[11:7]),
        .i_type   (w_type),
        .o_result (w_sh_res),
        .o_carry  (w_sh_carry)
    );
    always_comb begin
        w_operand = r_rm;
        w_carry   = r_c;
        if (r_imm) begin
            w_operand = w_imm_rot;
            w_carry   = w_rot == 5'd0 ? r_c : w_imm_rot[31];
        end else if (w_use_sh) begin
            w_operand = w_sh_res;
            w_carry   = w_sh_carry;
        end else if (!w_reg_sh) begin
            // Immediate amount 0: LSR/ASR mean 32, ROR means RRX
            if (w_type == SH_LSR) begin
                w_operand = '0;
                w_carry   = r_rm[31];
            end else if (w_type == SH_ASR) begin
                w_operand = {32{r_rm[31]}};
                w_carry   = r_rm[31];
            end else if (w_type == SH_ROR) begin
                w_operand = {r_c, r_rm[31:1]};
                w_carry   = r_rm[0];
            end
        end else if (r_rs != 8'd0) begin
            // Register amount >= 32 (or ROR by a multiple of 32)
            w_operand = w_type == SH_ASR ? {32{r_rm[31]}} : w_type == SH_ROR ? r_rm : '0;
            w_carry   = w_type == SH_LSL ? (r_rs == 8'd32) & r_rm[0] :
                        w_type == SH_LSR ? (r_rs == 8'd32) & r_rm[31] : r_rm[31];
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = !w_accept ? ST_IDLE : (!bus.imm_form & bus.instr[4]) ? ST_RS_WAIT : ST_EXEC;
            ST_RS_WAIT: w_next = w_last ? ST_EXEC : ST_RS_WAIT;
            ST_EXEC:    w_next = ST_DONE;
            ST_DONE:    w_next = bus.out_ready ? ST_IDLE : ST_DONE;
            default:    w_next = ST_IDLE;
        endcase
        if (bus.flush) w_next = ST_IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_imm     <= 1'b0;
            r_instr   <= '0;
            r_rm      <= '0;
            r_c       <= 1'b0;
            r_rs      <= '0;
            r_cnt     <= '0;
            r_operand <= '0;
            r_carry   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_imm   <= bus.imm_form;
                r_instr <= bus.instr;
                r_rm    <= bus.rm_val;
                r_c     <= bus.c_in;
                r_cnt   <= '0;
            end
            if (r_state == ST_RS_WAIT) begin
                r_cnt <= r_cnt + 2'd1;
                if (w_last) r_rs <= bus.rs_val;
            end
            if (r_state == ST_EXEC && !bus.flush) begin
                r_operand <= w_operand;
                r_carry   <= w_carry;
            end
        end
    end
    assign bus.in_ready  = (r_state == ST_IDLE) & !bus.flush;
    assign bus.rs_req    = (r_state == ST_RS_WAIT) & (r_cnt == 2'd0);
    assign bus.out_valid = r_state == ST_DONE;
    assign bus.operand   = r_operand;
    assign bus.carry_out = r_carry;
endmodule

// File: tb/tb_shifter_operand_ctrl.sv
// tb_shifter_operand_ctrl: table, corner-sequence and random checks of two sequencers (RS_LAT 1 and 3)
module tb_shifter_operand_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, imm_form = 1'b0, c_in = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [11:0] instr = '0;
    logic [31:0] rm_val = '0;
    logic [7:0]  rs_val = '0;
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;

    shifter_operand_if b1 ();
    shifter_operand_if b3 ();
    assign b1.in_valid = in_valid;  assign b3.in_valid = in_valid;
    assign b1.imm_form = imm_form;  assign b3.imm_form = imm_form;
    assign b1.instr = instr;        assign b3.instr = instr;
    assign b1.rm_val = rm_val;      assign b3.rm_val = rm_val;
    assign b1.c_in = c_in;          assign b3.c_in = c_in;
    assign b1.rs_val = rs_val;      assign b3.rs_val = rs_val;
    assign b1.flush = flush;        assign b3.flush = flush;
    assign b1.out_ready = out_ready; assign b3.out_ready = out_ready;

    shifter_operand_ctrl #(.RS_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
    shifter_operand_ctrl #(.RS_LAT(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

    typedef struct {
        string       nm;
        logic        imm;
        logic [11:0] ins;
        logic [31:0] rm;
        logic        c;
        logic [7:0]  rs;
        logic [31:0] op;
        logic        co;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ARM semantics as repeated one-bit steps: each step's carry is the bit that fell out
    function automatic void model(input logic imm, input logic [11:0] ins, input logic [31:0] rm,
                                  input logic c, input logic [7:0] rs, output logic [31:0] op, output logic co);
        int n;
        logic [1:0] t;
        t  = ins[6:5];
        op = rm;
        co = c;
        if (imm) begin
            op = {24'd0, ins[7:0]};
            n  = int'(ins[11:8]) * 2;
            for (int i = 0; i < n; i++) op = {op[0], op[31:1]};
            co = (n == 0) ? c : op[31];
            return;
        end
        if (ins[4]) n = int'(rs);
        else begin
            n = int'(ins[11:7]);
            if (n == 0 && t == 2'd3) begin
                op = {c, rm[31:1]};
                co = rm[0];
                return;
            end
            if (n == 0 && t != 2'd0) n = 32;
        end
        for (int i = 0; i < n; i++) begin
            case (t)
                2'd0: begin co = op[31]; op = op << 1; end
                2'd1: begin co = op[0]; op = op >> 1; end
                2'd2: begin co = op[0]; op = {op[31], op[31:1]}; end
                default: begin co = op[0]; op = {op[0], op[31:1]}; end
            endcase
        end
    endfunction

    task automatic run_op(input string nm, input logic imm, input logic [11:0] ins, input logic [31:0] rm,
                          input logic c, input logic [7:0] rs, input logic [31:0] eop, input logic ec);
        int lat1 = 0, lat3 = 0, rq1 = 0, rq3 = 0;
        logic [31:0] op1 = '0, op3 = '0;
        logic c1 = 1'b0, c3 = 1'b0;
        logic reg_form;
        reg_form = !imm & ins[4];
        @(negedge clk);
        in_valid = 1'b1; imm_form = imm; instr = ins; rm_val = rm; c_in = c; rs_val = rs;
        chk({nm, " in_ready"}, 32'({b1.in_ready, b3.in_ready}), 32'd3);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rq1 += int'(b1.rs_req);
            rq3 += int'(b3.rs_req);
            if (b1.out_valid && lat1 == 0) begin lat1 = e; op1 = b1.operand; c1 = b1.carry_out; end
            if (b3.out_valid && lat3 == 0) begin lat3 = e; op3 = b3.operand; c3 = b3.carry_out; end
        end
        chk({nm, " op L1"}, op1, eop);
        chk({nm, " c L1"}, 32'(c1), 32'(ec));
        chk({nm, " op L3"}, op3, eop);
        chk({nm, " c L3"}, 32'(c3), 32'(ec));
        chk({nm, " lat L1"}, 32'(lat1), reg_form ? 32'd3 : 32'd2);
        chk({nm, " lat L3"}, 32'(lat3), reg_form ? 32'd5 : 32'd2);
        chk({nm, " rs_req L1"}, 32'(rq1), reg_form ? 32'd1 : 32'd0);
        chk({nm, " rs_req L3"}, 32'(rq3), reg_form ? 32'd1 : 32'd0);
    endtask

    task automatic watch_idle(input string nm, input int edges);
        int seen = 0;
        for (int e = 0; e < edges; e++) begin
            @(posedge clk);
            #1;
            seen += int'(b1.out_valid) + int'(b3.out_valid);
        end
        chk({nm, " no out_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] eop;
        logic        ec;
        vecs[0]  = '{"lsl4",      1'b0, 12'h200, 32'h0000000A, 1'b1, 8'd0,  32'h000000A0, 1'b0};
        vecs[1]  = '{"lsr0",      1'b0, 12'h020, 32'h80000000, 1'b0, 8'd0,  32'h00000000, 1'b1};
        vecs[2]  = '{"asr0",      1'b0, 12'h040, 32'h80000000, 1'b0, 8'd0,  32'hFFFFFFFF, 1'b1};
        vecs[3]  = '{"rrx",       1'b0, 12'h060, 32'h00000001, 1'b1, 8'd0,  32'h80000000, 1'b1};
        vecs[4]  = '{"rlsl32",    1'b0, 12'h010, 32'h00000001, 1'b0, 8'd32, 32'h00000000, 1'b1};
        vecs[5]  = '{"rlsl33",    1'b0, 12'h010, 32'h00000001, 1'b1, 8'd33, 32'h00000000, 1'b0};
        vecs[6]  = '{"rlsl0",     1'b0, 12'h010, 32'h00000001, 1'b1, 8'd0,  32'h00000001, 1'b1};
        vecs[7]  = '{"rror32",    1'b0, 12'h070, 32'h80000001, 1'b0, 8'h20, 32'h80000001, 1'b1};
        vecs[8]  = '{"rror36",    1'b0, 12'h070, 32'h80000001, 1'b1, 8'h24, 32'h18000000, 1'b0};
        vecs[9]  = '{"imm_rot4",  1'b1, 12'h4FF, 32'h12345678, 1'b0, 8'd0,  32'hFF000000, 1'b1};
        vecs[10] = '{"imm_rot0",  1'b1, 12'h0FF, 32'h12345678, 1'b0, 8'd0,  32'h000000FF, 1'b0};
        vecs[11] = '{"lsr1",      1'b0, 12'h0A0, 32'h00000003, 1'b0, 8'd0,  32'h00000001, 1'b1};
        vecs[12] = '{"rasr40",    1'b0, 12'h050, 32'h80000000, 1'b0, 8'd40, 32'hFFFFFFFF, 1'b1};
        vecs[13] = '{"rlsr32",    1'b0, 12'h030, 32'h80000000, 1'b0, 8'd32, 32'h00000000, 1'b1};
        vecs[14] = '{"rlsl31",    1'b0, 12'h010, 32'h00000003, 1'b0, 8'd31, 32'h80000000, 1'b1};

        #12;
        chk("reset out_valid", 32'({b1.out_valid, b3.out_valid}), 32'd0);
        chk("reset rs_req", 32'({b1.rs_req, b3.rs_req}), 32'd0);
        chk("reset operand", b1.operand | b3.operand, 32'd0);
        chk("reset carry", 32'({b1.carry_out, b3.carry_out}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'({b1.in_ready, b3.in_ready}), 32'd3);

        foreach (vecs[i]) run_op(vecs[i].nm, vecs[i].imm, vecs[i].ins, vecs[i].rm, vecs[i].c, vecs[i].rs,
                                 vecs[i].op, vecs[i].co);

        // Result held while the consumer stalls
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; imm_form = 1'b1; instr = 12'h4FF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold operand", b1.operand, 32'hFF000000);
            chk("hold valid/ready", 32'({b1.out_valid, b3.out_valid, b1.in_ready, b3.in_ready}), 32'hC);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release", 32'({b1.out_valid, b3.out_valid, b1.in_ready, b3.in_ready}), 32'h3);

        // Flush while waiting for Rs
        @(negedge clk);
        in_valid = 1'b1; imm_form = 1'b0; instr = 12'h010; rm_val = 32'h1; rs_val = 8'd1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 chk("flush in_ready low", 32'({b1.in_ready, b3.in_ready}), 32'd0);
        @(negedge clk) flush = 1'b0;
        #1 chk("flush back to idle", 32'({b1.in_ready, b3.in_ready}), 32'd3);
        watch_idle("flush rs_wait", 7);

        // Flush blocks acceptance in IDLE
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; imm_form = 1'b1;
        #1 chk("flush idle in_ready", 32'({b1.in_ready, b3.in_ready}), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        watch_idle("flush idle", 6);

        // Reset during EXEC
        @(negedge clk);
        in_valid = 1'b1; imm_form = 1'b1; instr = 12'h4FF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst exec out_valid", 32'({b1.out_valid, b3.out_valid}), 32'd0);
        chk("rst exec operand", b1.operand | b3.operand, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        watch_idle("rst exec", 6);

        // Reset while DONE drops out_valid at once
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; imm_form = 1'b0; instr = 12'h200; rm_val = 32'h5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 chk("done before rst", 32'({b1.out_valid, b3.out_valid}), 32'd3);
        reset_n = 1'b0;
        #1 chk("rst done out_valid", 32'({b1.out_valid, b3.out_valid}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;

        for (int k = 0; k < 150; k++) begin
            logic        imm, c;
            logic [11:0] ins;
            logic [31:0] rm;
            logic [7:0]  rs;
            imm = $urandom_range(0, 3) == 0;
            c   = 1'($urandom);
            ins = 12'($urandom);
            rm  = $urandom_range(0, 3) == 0 ? 32'h80000001 : $urandom;
            case ($urandom_range(0, 4))
                0: rs = 8'd0;
                1: rs = 8'($urandom_range(31, 33));
                2: rs = 8'($urandom_range(1, 31));
                3: rs = 8'($urandom_range(2, 7) * 32);
                default: rs = 8'($urandom);
            endcase
            model(imm, ins, rm, c, rs, eop, ec);
            run_op($sformatf("rand%0d", k), imm, ins, rm, c, rs, eop, ec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
